epl_ecc_wr_sched: RTL and testbench

//   Round-robin write scheduler that shares one epl_ecc_encoder (Hamming(7,4), combinational codeword) among
//   NUM_REQ requesters. Accepts a 4*NIB-bit data word per grant and feeds it nibble-by-nibble through the

---
 rtl/epl_ecc_wr_sched.sv | 90 +++++++++
 tb/tb_epl_ecc_wr_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/epl_ecc_wr_sched.sv
// epl_ecc_wr_sched: round-robin write scheduler sharing one Hamming(7,4) encoder across requesters,
// feeding each accepted word nibble-by-nibble and packing the codewords with the owner's ID.
module epl_ecc_wr_sched #(
    parameter int NUM_REQ = 4,
    parameter int NIB     = 4,
    parameter int IDW     = 2
) (
    input  logic                     pCLK_i,
    input  logic                     pRST_i,
    input  logic [NUM_REQ-1:0]       pREQ_VALID_i,
    input  logic [NUM_REQ*4*NIB-1:0] pREQ_DATA_i,
    output logic [NUM_REQ-1:0]       pREQ_READY_o,
    output logic                     pENC_WRITE_o,
    output logic [3:0]               pENC_DATA_o,
    input  logic [6:0]               pENC_CODEWORD_i,
    input  logic                     pENC_VALID_i,
    output logic                     pOUT_VALID_o,
    output logic [7*NIB-1:0]         pOUT_CODEWORD_o,
    output logic [IDW-1:0]           pOUT_ID_o,
    input  logic                     pOUT_READY_i,
    output logic                     pBUSY_o
);
    localparam int IXW = NIB > 1 ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;
    state_t state, stateNext;
    logic [IDW-1:0] lastGrant, winner, curId, outId;
    logic [IXW-1:0] nibIdx;
    logic [4*NIB-1:0] word;
    logic [7*NIB-1:0] slots, slotsNext, outCw;
    logic found, lastNib, capture;
    // Lowest valid index above the pointer wins; otherwise the lowest at or below it.
    always_comb begin
        winner = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (pREQ_VALID_i[i] && i <= int'(lastGrant)) begin
                winner = IDW'(i);
                found = 1'b1;
            end
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (pREQ_VALID_i[i] && i > int'(lastGrant)) begin
                winner = IDW'(i);
                found = 1'b1;
            end
    end
    assign lastNib = nibIdx == IXW'(NIB - 1);
    assign capture = state == ENC && pENC_VALID_i;
    always_comb begin
        slotsNext = slots;
        if (capture) slotsNext[7*nibIdx +: 7] = pENC_CODEWORD_i;
        stateNext = state == IDLE ? (found ? ENC : IDLE) :
                    state == ENC  ? (capture && lastNib ? OUT : ENC) :
                    (pOUT_READY_i ? IDLE : OUT);
    end
    always_ff @(posedge pCLK_i) begin
        if (pRST_i) begin
            state     <= IDLE;
            lastGrant <= IDW'(NUM_REQ - 1);
            nibIdx    <= '0;
            word      <= '0;
            curId     <= '0;
            slots     <= '0;
            outCw     <= '0;
            outId     <= '0;
        end else begin
            state <= stateNext;
            slots <= slotsNext;
            if (state == IDLE && found) begin
                word      <= pREQ_DATA_i[4*NIB*winner +: 4*NIB];
                curId     <= winner;
                lastGrant <= winner;
                nibIdx    <= '0;
            end
            if (capture) begin
                nibIdx <= lastNib ? '0 : nibIdx + 1'b1;
                if (lastNib) begin
                    outCw <= slotsNext;
                    outId <= curId;
                end
            end
        end
    end
    assign pREQ_READY_o    = (state == IDLE && found) ? NUM_REQ'(1) << winner : '0;
    assign pENC_WRITE_o    = state == ENC;
    assign pENC_DATA_o     = state == ENC ? word[4*nibIdx +: 4] : 4'd0;
    assign pOUT_VALID_o    = state == OUT;
    assign pOUT_CODEWORD_o = outCw;
    assign pOUT_ID_o       = outId;
    assign pBUSY_o         = state != IDLE;
endmodule

// File: tb/tb_epl_ecc_wr_sched.sv
// tb_epl_ecc_wr_sched: table-driven and scoreboard checks of the round-robin ECC write scheduler
// with a behavioural Hamming(7,4) encoder model standing in for the shared encoder.
module tb_epl_ecc_wr_sched;
    localparam int NUM_REQ = 4;
    localparam int NIB = 4;
    localparam int IDW = 2;
    typedef struct {
        logic [3:0]  mask;
        logic [15:0] word;
        int          expId;
        bit          chkCw;
        logic [27:0] expCw;
    } vec_t;
    typedef struct {
        logic [1:0]  id;
        logic [27:0] cw;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, outReady = 1'b1;
    logic [3:0] reqValid = '0, reqReady;
    logic [63:0] reqData = '0;
    logic encWrite, encValid, outValid, busy;
    logic [3:0] encData;
    logic [6:0] encCw;
    logic [27:0] outCw;
    logic [1:0] outId;
    int checks = 0, errors = 0, cyc = 0;
    exp_t sb[$];
    logic [3:0] encLog[$];
    vec_t tbl[10];
    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[3], d[2], d[1], ~(d[1] ^ d[2] ^ d[3]), d[0], ~(d[0] ^ d[2] ^ d[3]), ~(d[0] ^ d[1] ^ d[3])};
    endfunction
    function automatic logic [27:0] pack(input logic [15:0] w);
        logic [27:0] p;
        for (int k = 0; k < NIB; k++) p[7*k +: 7] = enc(w[4*k +: 4]);
        return p;
    endfunction
    assign encCw = enc(encData);
    assign encValid = encWrite & ~stall;
    epl_ecc_wr_sched #(.NUM_REQ(NUM_REQ), .NIB(NIB), .IDW(IDW)) dut (
        .pCLK_i(clk), .pRST_i(rst), .pREQ_VALID_i(reqValid), .pREQ_DATA_i(reqData),
        .pREQ_READY_o(reqReady), .pENC_WRITE_o(encWrite), .pENC_DATA_o(encData),
        .pENC_CODEWORD_i(encCw), .pENC_VALID_i(encValid), .pOUT_VALID_o(outValid),
        .pOUT_CODEWORD_o(outCw), .pOUT_ID_o(outId), .pOUT_READY_i(outReady), .pBUSY_o(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask
    // Scoreboard: push on every accepted word, pop on every accepted output.
    always @(negedge clk) begin
        exp_t e;
        if (rst) sb.delete();
        else begin
            for (int r = 0; r < NUM_REQ; r++)
                if (reqValid[r] && reqReady[r]) begin
                    e.id = 2'(r);
                    e.cw = pack(reqData[16*r +: 16]);
                    sb.push_back(e);
                end
            if (encWrite && encValid) encLog.push_back(encData);
            if (outValid && outReady) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got id=%0d cw=%h, required no output", outId, outCw);
                end else begin
                    e = sb.pop_front();
                    if (outId !== e.id || outCw !== e.cw) begin
                        errors++;
                        $display("FAIL out_word: got id=%0d cw=%h, required id=%0d cw=%h", outId, outCw, e.id, e.cw);
                    end
                end
            end
        end
    end
    task automatic runOne(input logic [3:0] mask, input logic [15:0] word, input int expId,
                          input int stallAt, input int stallLen, input bit chkCw, input logic [27:0] expCw);
        int t0, gid;
        bit got;
        logic [15:0] seq;
        @(posedge clk); #1;
        reqValid = mask;
        for (int r = 0; r < NUM_REQ; r++) reqData[16*r +: 16] = word;
        t0 = -1;
        gid = -1;
        for (int c = 0; c < 20 && t0 < 0; c++) begin
            @(negedge clk);
            for (int r = 0; r < NUM_REQ; r++) if (reqValid[r] && reqReady[r]) begin t0 = cyc; gid = r; end
        end
        if (t0 < 0) begin
            checks++; errors++;
            $display("FAIL grant_timeout: got no grant, required grant to %0d", expId);
            reqValid = '0;
            return;
        end
        encLog.delete();
        chk("grant_id", gid, expId);
        @(posedge clk); #1 reqValid = '0;
        if (stallAt >= 0) begin
            repeat (stallAt) @(posedge clk);
            #1 stall = 1'b1;
            for (int s = 0; s < stallLen; s++) begin
                @(negedge clk);
                chk("stall_nibble", encData, word[4*stallAt +: 4]);
                @(posedge clk);
            end
            #1 stall = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = outValid;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL out_timeout: got no pOUT_VALID_o, required one");
            return;
        end
        chk("latency", cyc - t0, 5 + (stallAt >= 0 ? stallLen : 0));
        seq = '0;
        foreach (encLog[i]) if (i < 4) seq[4*i +: 4] = encLog[i];
        chk("enc_count", encLog.size(), 4);
        chk("enc_seq", seq, word);
        if (chkCw) chk("out_cw_const", outCw, expCw);
    endtask
    initial begin
        #50000;
        $display("FAIL watchdog: got no finish, required finish before 50000");
        $fatal(1);
    end
    initial begin
        int n, ids[5], ts[5];
        logic [27:0] cw0;
        logic [1:0] id0;
        bit got;
        logic [15:0] w;
        tbl[0] = '{4'b0001, 16'h000F, 0, 1'b1, 28'h162C5F4};
        tbl[1] = '{4'b0100, 16'h0000, 2, 1'b1, 28'h162C58B};
        tbl[2] = '{4'b1111, 16'hA5C3, 3, 1'b0, 28'h0};
        tbl[3] = '{4'b0011, 16'h1234, 0, 1'b0, 28'h0};
        tbl[4] = '{4'b0011, 16'hFFFF, 1, 1'b0, 28'h0};
        tbl[5] = '{4'b1000, 16'h8421, 3, 1'b0, 28'h0};
        tbl[6] = '{4'b0101, 16'h7E18, 0, 1'b0, 28'h0};
        tbl[7] = '{4'b1110, 16'hBEEF, 1, 1'b0, 28'h0};
        tbl[8] = '{4'b1010, 16'h0F0F, 3, 1'b0, 28'h0};
        tbl[9] = '{4'b0110, 16'h5555, 1, 1'b0, 28'h0};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {reqReady, busy, encWrite, encData, outValid, outId, outCw}, 0);
        foreach (tbl[i]) runOne(tbl[i].mask, tbl[i].word, tbl[i].expId, -1, 0, tbl[i].chkCw, tbl[i].expCw);
        // All requesters continuously valid after a fresh reset.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        reqValid = 4'hF;
        for (int r = 0; r < NUM_REQ; r++) reqData[16*r +: 16] = 16'(16'h1357 * (r + 1));
        n = 0;
        for (int c = 0; c < 80 && n < 5; c++) begin
            @(negedge clk);
            for (int r = 0; r < NUM_REQ; r++) if (reqValid[r] && reqReady[r] && n < 5) begin ids[n] = r; ts[n] = cyc; n++; end
            if (n == 5) begin @(posedge clk); #1 reqValid = '0; end
        end
        reqValid = '0;
        chk("rr_count", n, 5);
        for (int i = 0; i < n; i++) chk("rr_order", ids[i], i % NUM_REQ);
        for (int i = 1; i < n; i++) chk("rr_spacing", ts[i] - ts[i-1], NIB + 2);
        repeat (10) @(posedge clk);
        // Output backpressure: word held, no grants while OUT waits.
        outReady = 1'b0;
        runOne(4'b0010, 16'hBEAD, 1, -1, 0, 1'b0, 28'h0);
        cw0 = outCw;
        id0 = outId;
        @(posedge clk); #1 reqValid = 4'hF;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("bp_hold", {outValid, outId, outCw, reqReady}, {1'b1, id0, cw0, 4'b0000});
        end
        @(posedge clk); #1;
        reqValid = '0;
        outReady = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release", {busy, outValid}, 0);
        chk("bp_cw_hold", outCw, cw0);
        // Encoder stall at nibble 2 for 3 cycles.
        runOne(4'b1000, 16'h1234, 3, 2, 3, 1'b0, 28'h0);
        repeat (3) @(posedge clk);
        // Reset while encoding nibble 1.
        w = 16'h9A7B;
        @(posedge clk); #1;
        reqValid = 4'b0010;
        for (int r = 0; r < NUM_REQ; r++) reqData[16*r +: 16] = w;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = |(reqValid & reqReady);
        end
        chk("rst_accept", got, 1);
        @(posedge clk); #1 reqValid = '0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_idx1", encData, w[7:4]);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_clear", {reqReady, busy, encWrite, encData, outValid, outId, outCw}, 0);
        runOne(4'hF, 16'hC0DE, 0, -1, 0, 1'b0, 28'h0);
        repeat (5) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
